// File: rtl/mdu.sv
// mult/multu/div/divu with fixed MULT_CYCLES/DIV_CYCLES latency; mthi/mtlo write in one edge.
// No backpressure: start is dropped while busy, so the hazard unit must stall on start | busy.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        out_sel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] out
);
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic [7:0]  r_cnt;
    logic        r_busy;
    logic [31:0] r_hi, r_lo;
    logic [31:0] r_pend_hi, r_pend_lo;
    logic        r_pend_wr;

    logic               w_accept;
    logic signed [63:0] w_sa, w_sb, w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_b_zero, w_ovf;
    logic signed [31:0] w_as, w_bs;
    logic signed [31:0] w_q_s, w_r_s;
    logic        [31:0] w_bu, w_q_u, w_r_u;

    assign w_accept = start && !r_busy && (op >= OP_MULT) && (op <= OP_MTLO);

    assign w_sa     = {{32{A[31]}}, A};
    assign w_sb     = {{32{B[31]}}, B};
    assign w_prod_s = w_sa * w_sb;
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Divisor forced to 1 on zero and the INT_MIN / -1 case handled explicitly,
    // so the dividers never see an undefined operation.
    assign w_b_zero = (B == 32'd0);
    assign w_ovf    = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign w_as     = $signed(A);
    assign w_bs     = (w_b_zero || w_ovf) ? 32'sd1 : $signed(B);
    assign w_q_s    = w_ovf ? $signed(32'h8000_0000) : (w_as / w_bs);
    assign w_r_s    = w_ovf ? 32'sd0 : (w_as % w_bs);
    assign w_bu     = w_b_zero ? 32'd1 : B;
    assign w_q_u    = A / w_bu;
    assign w_r_u    = A % w_bu;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= 8'd0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else if (r_busy) begin
            r_cnt <= r_cnt - 8'd1;
            if (r_cnt == 8'd1) begin
                r_busy    <= 1'b0;
                r_pend_wr <= 1'b0;
                if (r_pend_wr) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
            end
        end else if (w_accept) begin
            case (op)
                OP_MULT: begin
                    r_pend_hi <= w_prod_s[63:32];
                    r_pend_lo <= w_prod_s[31:0];
                    r_pend_wr <= 1'b1;
                    r_cnt     <= MULT_CYCLES[7:0];
                    r_busy    <= 1'b1;
                end
                OP_MULTU: begin
                    r_pend_hi <= w_prod_u[63:32];
                    r_pend_lo <= w_prod_u[31:0];
                    r_pend_wr <= 1'b1;
                    r_cnt     <= MULT_CYCLES[7:0];
                    r_busy    <= 1'b1;
                end
                OP_DIV: begin
                    r_pend_hi <= w_r_s;
                    r_pend_lo <= w_q_s;
                    r_pend_wr <= !w_b_zero;
                    r_cnt     <= DIV_CYCLES[7:0];
                    r_busy    <= 1'b1;
                end
                OP_DIVU: begin
                    r_pend_hi <= w_r_u;
                    r_pend_lo <= w_q_u;
                    r_pend_wr <= !w_b_zero;
                    r_cnt     <= DIV_CYCLES[7:0];
                    r_busy    <= 1'b1;
                end
                OP_MTHI: r_hi <= A;
                OP_MTLO: r_lo <= A;
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;
    assign out  = out_sel ? r_hi : r_lo;
endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: hand-computed HI/LO results, busy length, reset and busy interactions.
module tb_mdu;
    logic        clk = 1'b0;
    logic        reset, start, out_sel;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO, out;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .out_sel(out_sel), .busy(busy), .HI(HI), .LO(LO), .out(out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Presents one request for a single edge; returns 1 time unit after that edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 32'hA5A5_A5A5; B = 32'h5A5A_5A5A;
    endtask

    // Counts edges until busy drops, bounded so a stuck busy still ends the run.
    task automatic wait_busy(input string tag, input int exp_cycles);
        int n = 0;
        while (busy && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, n, exp_cycles);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'b000; A = '0; B = '0; out_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_out", out, 32'd0);

        // mult: -1 * 2 = -2
        issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        check("mult_busy_now", {31'd0, busy}, 32'd1);
        check("mult_hold_hi", HI, 32'd0);
        check("mult_hold_lo", LO, 32'd0);
        @(posedge clk); #1;
        check("mult_hold_lo2", LO, 32'd0);
        wait_busy("mult_cycles", 4);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFE);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        check("multu_hold_lo", LO, 32'hFFFF_FFFE);
        wait_busy("multu_cycles", 5);
        check("multu_hi", HI, 32'h0000_0001);
        check("multu_lo", LO, 32'hFFFF_FFFE);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_busy("div_cycles", 10);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        issue(OP_DIVU, 32'd7, 32'd2);
        wait_busy("divu_cycles", 10);
        check("divu_lo", LO, 32'd3);
        check("divu_hi", HI, 32'd1);

        issue(OP_MTHI, 32'h11, 32'd0);
        issue(OP_MTLO, 32'h22, 32'd0);
        issue(OP_DIV, 32'd1234, 32'd0);
        wait_busy("div0_cycles", 10);
        check("div0_hi", HI, 32'h11);
        check("div0_lo", LO, 32'h22);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_busy("ovf_cycles", 10);
        check("ovf_lo", LO, 32'h8000_0000);
        check("ovf_hi", HI, 32'h0);

        issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_hi", HI, 32'hDEAD_BEEF);
        check("mthi_lo_kept", LO, 32'h8000_0000);
        issue(OP_MTLO, 32'h1234_5678, 32'd0);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        check("mtlo_lo", LO, 32'h1234_5678);
        check("mtlo_hi_kept", HI, 32'hDEAD_BEEF);
        out_sel = 1'b1; #1;
        check("out_hi", out, 32'hDEAD_BEEF);
        out_sel = 1'b0; #1;
        check("out_lo", out, 32'h1234_5678);

        // mult issued while a divu is in flight must vanish: 100/7 = 14 r 2
        issue(OP_DIVU, 32'd100, 32'd7);
        issue(OP_MULT, 32'd3, 32'd4);
        wait_busy("ign_cycles", 9);
        check("ign_lo", LO, 32'd14);
        check("ign_hi", HI, 32'd2);
        @(posedge clk); #1;
        check("ign_no_mult", {31'd0, busy}, 32'd0);

        // start on the commit edge is dropped: 9/2 = 4 r 1
        issue(OP_DIVU, 32'd9, 32'd2);
        repeat (9) @(posedge clk);
        #1;
        op = OP_MULT; A = 32'd5; B = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("commit_busy", {31'd0, busy}, 32'd0);
        check("commit_lo", LO, 32'd4);
        check("commit_hi", HI, 32'd1);
        @(posedge clk); #1;
        check("commit_no_mult", {31'd0, busy}, 32'd0);

        // reset during busy cycle 3 of a div discards the pending result
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_hi", HI, 32'd0);
        check("mid_rst_lo", LO, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("late_busy", {31'd0, busy}, 32'd0);
        check("late_hi", HI, 32'd0);
        check("late_lo", LO, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the EX stage of the five-stage MIPS pipeline. It executes mult/multu/div/divu with a fixed multi-cycle latency, and handles mthi/mtlo writes into the architectural HI/LO registers. It also presents HI or LO for mfhi/mflo so the value flows into the EX/MEM register alongside the ALU result. The hazard unit stalls the D stage on `start | busy` whenever an MDU-class instruction is in D.

## Interface
- `MULT_CYCLES`, default 5: busy duration for mult/multu, range 1..255.
- `DIV_CYCLES`, default 10: busy duration for div/divu, range 1..255.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `start` input 1: single-cycle request qualifying `op`.
- `op` input 3: 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo. Other codes are no-op.
- `A` input 32: rs operand, already forwarded.
- `B` input 32: rt operand, already forwarded.
- `out_sel` input 1: 0 selects LO, 1 selects HI.
- `busy` output 1: high while a mult/div is in flight.
- `HI` output 32: architectural HI register.
- `LO` output 32: architectural LO register.
- `out` output 32: combinational `out_sel ? HI : LO`.

## Operation
- Acceptance: an op is accepted on an edge where `start`=1, `busy`=0, `reset`=0 and `op` is valid. `start` while `busy`=1 is ignored entirely: no state change and the counter continues.
- mthi/mtlo: at the accept edge, HI (or LO) <= `A`. `busy` is not asserted. The other register is unchanged.
- mult/multu:
  - At the accept edge, compute the 64-bit product into an internal pending register. Signed for mult, unsigned for multu.
  - Load the counter with `MULT_CYCLES`; `busy` goes to 1.
- div/divu:
  - At the accept edge, compute the pending LO=quotient and HI=remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
  - Load the counter with `DIV_CYCLES`.
- Divide by zero (`B`=0): the op is accepted and `busy` runs for the full `DIV_CYCLES`. HI/LO are left unchanged at completion.
- Counter:
  - 8 bits, decrements by 1 per edge while nonzero.
  - `busy` is a registered flag, equal to counter != 0.
  - On the edge where the counter goes 1->0, commit pending HI/LO and clear `busy` on that same edge.
- HI/LO hold their value between writes. A pending result is never visible before commit.
- Reset, including mid-operation: HI=0, LO=0, `busy`=0, counter=0, pending discarded. `reset` has priority over `start`.

## Timing
- Accept at edge E0: `busy`=1 after E0. For mult, `busy`=0 and the new HI/LO are visible after edge E0+MULT_CYCLES. `busy` is high for exactly `MULT_CYCLES` cycles (or `DIV_CYCLES` for div).
- mthi/mtlo accepted at E0: the new value is visible on `HI`/`LO`/`out` after E0. Zero busy cycles.
- `out` has no register: it follows HI/LO and `out_sel` in the same cycle.
- Back-to-back: a new `start` is accepted on the first edge where `busy`=0. A `start` coinciding with the commit edge (`busy`=1 at that edge) is ignored.
- Operands are sampled only at the accept edge. Later changes on `A`/`B` have no effect.

## Test plan
- mult A=0xFFFFFFFF, B=0x00000002, default parameters:
  - `busy`=1 for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - HI/LO keep their old values while `busy`=1.
- multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div and divu, 10 busy cycles each:
  - div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=2 -> LO=3, HI=1.
- Boundary divides:
  - div with B=0 after a prior HI=0x11, LO=0x22 -> 10 busy cycles, then HI=0x11, LO=0x22.
  - div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi A=0xDEADBEEF, next cycle mtlo A=0x12345678:
  - HI then LO update after one edge each, with `busy` never asserted.
  - `out_sel`=1 gives `out`=0xDEADBEEF.
- Busy and reset interactions:
  - `start`(mult) issued while busy with a div: ignored; the div result commits on schedule.
  - `reset` at busy cycle 3 of a div: next cycle `busy`=0, HI=LO=0, and no later commit occurs.
